// File: rtl/dmem_ctrl.sv
// Memory-stage data access controller: lane steering, load extension and a
// request/acknowledge bus handshake that holds the pipeline while a transfer is in flight.
module dmem_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        MisalignM,
    output logic        BusErrM,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [CNT_W-1:0]   cnt_r;
    logic               err_r;
    logic               we_r;
    logic [1:0]         off_r;
    logic [2:0]         f3_r;
    logic [31:0]        rdata_r;
    logic               bus_req_r;
    logic               bus_we_r;
    logic [31:0]        bus_addr_r;
    logic [31:0]        bus_wdata_r;
    logic [3:0]         bus_be_r;

    logic               acc_s;
    logic               misalign_s;
    logic               start_s;
    logic               capture_s;
    logic               timeout_s;
    logic [3:0]         be_s;
    logic [31:0]        wdata_s;

    function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be_v;
        case (f3[1:0])
            2'b00:   be_v = 4'b0001 << off;
            2'b01:   be_v = 4'b0011 << off;
            default: be_v = 4'b1111;
        endcase
        return be_v;
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] wd_v;
        case (f3[1:0])
            2'b00:   wd_v = {4{wd[7:0]}};
            2'b01:   wd_v = {2{wd[15:0]}};
            default: wd_v = wd;
        endcase
        return wd_v;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic mis_v;
        case (f3[1:0])
            2'b00:   mis_v = 1'b0;
            2'b01:   mis_v = off[0];
            default: mis_v = (off != 2'b00);
        endcase
        return mis_v;
    endfunction

    // The byte offset moves the addressed lane down to bit 0 before extension.
    function automatic logic [31:0] fmt_load(input logic [31:0] word, input logic [1:0] off,
                                             input logic [2:0] f3);
        logic [31:0] sh_v;
        logic [31:0] res_v;
        sh_v = word >> {off, 3'b000};
        case (f3)
            3'b000:  res_v = {{24{sh_v[7]}}, sh_v[7:0]};
            3'b001:  res_v = {{16{sh_v[15]}}, sh_v[15:0]};
            3'b100:  res_v = {24'h00_0000, sh_v[7:0]};
            3'b101:  res_v = {16'h0000, sh_v[15:0]};
            default: res_v = sh_v;
        endcase
        return res_v;
    endfunction

    assign acc_s      = (MemReadM | MemWriteM) & reset;
    assign misalign_s = is_misaligned(Funct3M, ALUResultM[1:0]);
    assign be_s       = lane_be(Funct3M, ALUResultM[1:0]);
    assign wdata_s    = lane_wdata(Funct3M, WriteDataM);

    assign bus_req    = bus_req_r;
    assign bus_we     = bus_we_r;
    assign bus_addr   = bus_addr_r;
    assign bus_wdata  = bus_wdata_r;
    assign bus_be     = bus_be_r;

    // Next-state decode and the pipeline-facing status outputs.
    always_comb begin
        state_next_s = state_r;
        StallM       = 1'b0;
        MisalignM    = 1'b0;
        BusErrM      = 1'b0;
        ReadDataM    = 32'h0000_0000;
        start_s      = 1'b0;
        capture_s    = 1'b0;
        timeout_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (acc_s) begin
                    if (misalign_s) begin
                        MisalignM = 1'b1;
                    end else begin
                        StallM       = 1'b1;
                        start_s      = 1'b1;
                        state_next_s = BUSY;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUSY: begin
                StallM = 1'b1;
                if (bus_ack) begin
                    capture_s    = 1'b1;
                    state_next_s = DONE;
                end else if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
                    timeout_s    = 1'b1;
                    state_next_s = DONE;
                end else begin
                    state_next_s = BUSY;
                end
            end
            DONE: begin
                BusErrM      = err_r;
                state_next_s = IDLE;
                if (we_r) begin
                    ReadDataM = 32'h0000_0000;
                end else begin
                    ReadDataM = fmt_load(rdata_r, off_r, f3_r);
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, request registers, timeout counter and captured read word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            err_r       <= 1'b0;
            we_r        <= 1'b0;
            off_r       <= 2'b00;
            f3_r        <= 3'b000;
            rdata_r     <= 32'h0000_0000;
            bus_req_r   <= 1'b0;
            bus_we_r    <= 1'b0;
            bus_addr_r  <= 32'h0000_0000;
            bus_wdata_r <= 32'h0000_0000;
            bus_be_r    <= 4'b0000;
        end else begin
            state_r <= state_next_s;
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        bus_req_r   <= 1'b1;
                        bus_we_r    <= MemWriteM;
                        bus_addr_r  <= {ALUResultM[31:2], 2'b00};
                        bus_wdata_r <= wdata_s;
                        bus_be_r    <= be_s;
                        we_r        <= MemWriteM;
                        off_r       <= ALUResultM[1:0];
                        f3_r        <= Funct3M;
                        rdata_r     <= 32'h0000_0000;
                        err_r       <= 1'b0;
                        cnt_r       <= '0;
                    end
                end
                BUSY: begin
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (capture_s || timeout_s) begin
                        rdata_r     <= capture_s ? bus_rdata : 32'h0000_0000;
                        err_r       <= timeout_s;
                        bus_req_r   <= 1'b0;
                        bus_we_r    <= 1'b0;
                        bus_addr_r  <= 32'h0000_0000;
                        bus_wdata_r <= 32'h0000_0000;
                        bus_be_r    <= 4'b0000;
                    end
                end
                DONE: begin
                    cnt_r <= '0;
                    err_r <= 1'b0;
                end
                default: begin
                    cnt_r <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: each access is driven through the handshake
// and its bus fields, stall count and returned data are compared with hand values.
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemReadM, MemWriteM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM, WriteDataM, ReadDataM;
    logic        StallM, MisalignM, BusErrM;
    logic        bus_req, bus_we, bus_ack;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;

    int n_cmp = 0;
    int n_err = 0;

    int          r_stalls, r_reqs;
    logic [31:0] r_addr, r_wdata, r_rd;
    logic [3:0]  r_be;
    logic        r_we, r_err, r_done;

    always #5 clk = ~clk;

    dmem_ctrl #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk(clk), .reset(reset),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM), .Funct3M(Funct3M),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .ReadDataM(ReadDataM),
        .StallM(StallM), .MisalignM(MisalignM), .BusErrM(BusErrM),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_be(bus_be),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // ack_at is the 0-based BUSY cycle that sees bus_ack; -1 never acks.
    task automatic run_acc(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int ack_at, input logic [31:0] rdata);
        MemReadM = rd; MemWriteM = wr; Funct3M = f3; ALUResultM = addr; WriteDataM = wd;
        bus_ack = 1'b0; bus_rdata = 32'h0;
        #1;
        r_stalls = StallM ? 1 : 0;
        r_reqs = 0; r_done = 1'b0;
        r_addr = 32'h0; r_wdata = 32'h0; r_be = 4'h0; r_we = 1'b0; r_rd = 32'hFFFF_FFFF; r_err = 1'b0;
        for (int c = 0; c < 40 && !r_done; c++) begin
            cyc();
            if (bus_req) begin
                if (r_reqs == 0) begin
                    r_addr = bus_addr; r_wdata = bus_wdata; r_be = bus_be; r_we = bus_we;
                end
                bus_ack   = (r_reqs == ack_at);
                bus_rdata = (r_reqs == ack_at) ? rdata : 32'h0;
                r_reqs++;
                #1;
                if (StallM) r_stalls++;
            end else begin
                bus_ack = 1'b0;
                r_rd = ReadDataM; r_err = BusErrM; r_done = 1'b1;
                if (StallM) r_stalls++;
            end
        end
        MemReadM = 1'b0; MemWriteM = 1'b0; bus_ack = 1'b0;
        cyc();
    endtask

    task automatic expect_acc(input string tag, input int stalls, input int reqs,
                              input logic [31:0] addr, input logic [3:0] be, input logic we,
                              input logic [31:0] wdata, input logic [31:0] rd, input logic err);
        check_eq({tag, "_done"},  {31'h0, r_done}, 32'h1);
        check_eq({tag, "_stall"}, r_stalls, stalls);
        check_eq({tag, "_reqs"},  r_reqs, reqs);
        check_eq({tag, "_addr"},  r_addr, addr);
        check_eq({tag, "_be"},    {28'h0, r_be}, {28'h0, be});
        check_eq({tag, "_we"},    {31'h0, r_we}, {31'h0, we});
        check_eq({tag, "_wdata"}, r_wdata, wdata);
        check_eq({tag, "_rdata"}, r_rd, rd);
        check_eq({tag, "_err"},   {31'h0, r_err}, {31'h0, err});
    endtask

    task automatic mis_acc(input string tag, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr);
        MemReadM = ~wr; MemWriteM = wr; Funct3M = f3; ALUResultM = addr; WriteDataM = 32'h1111_2222;
        #1;
        check_eq({tag, "_mis"},   {31'h0, MisalignM}, 32'h1);
        check_eq({tag, "_stall"}, {31'h0, StallM}, 32'h0);
        check_eq({tag, "_rdata"}, ReadDataM, 32'h0);
        cyc();
        check_eq({tag, "_req"},   {31'h0, bus_req}, 32'h0);
        MemReadM = 1'b0; MemWriteM = 1'b0;
        #1;
        check_eq({tag, "_mis_off"}, {31'h0, MisalignM}, 32'h0);
        cyc();
        check_eq({tag, "_req2"},  {31'h0, bus_req}, 32'h0);
    endtask

    initial begin
        reset = 1'b0; MemReadM = 1'b0; MemWriteM = 1'b0; Funct3M = 3'b000;
        ALUResultM = 32'h0; WriteDataM = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
        cyc(); cyc();
        check_eq("rst_req",   {31'h0, bus_req}, 32'h0);
        check_eq("rst_stall", {31'h0, StallM}, 32'h0);
        check_eq("rst_rdata", ReadDataM, 32'h0);
        check_eq("rst_addr",  bus_addr, 32'h0);
        check_eq("rst_be",    {28'h0, bus_be}, 32'h0);
        check_eq("rst_err",   {31'h0, BusErrM}, 32'h0);
        reset = 1'b1;
        cyc();

        run_acc(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 0, 32'hDEAD_BEEF);
        expect_acc("lw", 2, 1, 32'h0000_0100, 4'b1111, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0);
        run_acc(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 0, 32'h80FF_0000);
        expect_acc("lb", 2, 1, 32'h0000_0100, 4'b1000, 1'b0, 32'h0, 32'hFFFF_FF80, 1'b0);
        run_acc(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0, 0, 32'h80FF_0000);
        expect_acc("lbu", 2, 1, 32'h0000_0100, 4'b1000, 1'b0, 32'h0, 32'h0000_0080, 1'b0);
        run_acc(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 0, 32'h5555_5555);
        expect_acc("sh", 2, 1, 32'h0000_0200, 4'b1100, 1'b1, 32'hABCD_ABCD, 32'h0, 1'b0);
        run_acc(1'b0, 1'b1, 3'b000, 32'h0000_0101, 32'h0000_00A5, 1, 32'h0);
        expect_acc("sb_wait1", 3, 2, 32'h0000_0100, 4'b0010, 1'b1, 32'hA5A5_A5A5, 32'h0, 1'b0);
        run_acc(1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0, 2, 32'h8001_7777);
        expect_acc("lh_wait2", 4, 3, 32'h0000_0100, 4'b1100, 1'b0, 32'h0, 32'hFFFF_8001, 1'b0);
        run_acc(1'b1, 1'b0, 3'b101, 32'h0000_0100, 32'h0, 0, 32'h1234_8765);
        expect_acc("lhu", 2, 1, 32'h0000_0100, 4'b0011, 1'b0, 32'h0, 32'h0000_8765, 1'b0);
        run_acc(1'b1, 1'b1, 3'b010, 32'h0000_0010, 32'hCAFE_BABE, 0, 32'h1111_1111);
        expect_acc("rw_both", 2, 1, 32'h0000_0010, 4'b1111, 1'b1, 32'hCAFE_BABE, 32'h0, 1'b0);

        run_acc(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0, -1, 32'h0);
        expect_acc("timeout", 17, 16, 32'h0000_0300, 4'b1111, 1'b0, 32'h0, 32'h0, 1'b1);
        check_eq("to_idle_stall", {31'h0, StallM}, 32'h0);
        check_eq("to_idle_err",   {31'h0, BusErrM}, 32'h0);
        check_eq("to_idle_req",   {31'h0, bus_req}, 32'h0);

        mis_acc("mis_lw", 1'b0, 3'b010, 32'h0000_0102);
        mis_acc("mis_lh", 1'b0, 3'b001, 32'h0000_0101);
        mis_acc("mis_sw", 1'b1, 3'b010, 32'h0000_0201);

        MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h0000_0400;
        #1;
        cyc(); cyc(); cyc();
        check_eq("rst_mid_busy", {31'h0, bus_req}, 32'h1);
        reset = 1'b0; MemReadM = 1'b0;
        #1;
        check_eq("rst_mid_req",   {31'h0, bus_req}, 32'h0);
        check_eq("rst_mid_stall", {31'h0, StallM}, 32'h0);
        check_eq("rst_mid_addr",  bus_addr, 32'h0);
        cyc();
        reset = 1'b1;
        cyc();
        bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
        #1;
        check_eq("late_ack_req",   {31'h0, bus_req}, 32'h0);
        check_eq("late_ack_stall", {31'h0, StallM}, 32'h0);
        check_eq("late_ack_rdata", ReadDataM, 32'h0);
        cyc();
        bus_ack = 1'b0;
        check_eq("late_ack_req2",   {31'h0, bus_req}, 32'h0);
        check_eq("late_ack_rdata2", ReadDataM, 32'h0);
        check_eq("late_ack_err",    {31'h0, BusErrM}, 32'h0);

        run_acc(1'b1, 1'b0, 3'b010, 32'h0000_0404, 32'h0, 0, 32'h0102_0304);
        expect_acc("lw_after_rst", 2, 1, 32'h0000_0404, 4'b1111, 1'b0, 32'h0, 32'h0102_0304, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Memory-stage data access controller. Sits directly downstream of the pipelined datapath's Execute/Memory register and consumes its memory-stage outputs: MemWriteM, ALUResultM, WriteDataM, ResultSrcM and funct3 of InstrM.
- Drives a word-wide request/acknowledge data bus, performs byte/halfword lane steering and load extension, and returns ReadDataM to the datapath.
- Raises StallM to freeze the whole pipeline while a bus access is outstanding.

Parameters:
- TIMEOUT, 16, max cycles waiting for bus_ack before aborting the access (>=2).
- CNT_W, 5, width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- MemReadM  in  1  load in memory stage (ResultSrcM==2'b01).
- MemWriteM  in  1  store in memory stage.
- Funct3M  in  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- ALUResultM  in  32  byte address.
- WriteDataM  in  32  store data, right-aligned.
- ReadDataM  out  32  aligned, extended load data.
- StallM  out  1  pipeline hold request.
- MisalignM  out  1  misaligned access flagged (single-cycle pulse).
- BusErrM  out  1  timeout abort flagged (single-cycle pulse).
- bus_req  out  1  bus request.
- bus_we  out  1  write enable.
- bus_addr  out  32  word address; bits [1:0] always 0.
- bus_wdata  out  32  lane-steered store data.
- bus_be  out  4  byte enables.
- bus_ack  in  1  access complete; bus_rdata valid in the same cycle.
- bus_rdata  in  32  read word.

Behaviour:
- Reset (reset==0, async): FSM=IDLE, counter=0, all registered outputs 0. Bus outputs and status outputs are 0; ReadDataM=0 and StallM=0.
- Access: acc = MemReadM|MemWriteM. If both inputs are high, treat it as a write.
- Misalignment: half with addr[0]!=0, or word with addr[1:0]!=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - acc and aligned: StallM=1 combinationally. On the next edge, register bus_addr={addr[31:2],2'b00}, bus_we, bus_be, bus_wdata, addr[1:0] and Funct3M, then go to BUSY.
  - acc and misaligned: no bus activity. MisalignM=1, StallM=0 and ReadDataM=0 in the same cycle; stay in IDLE. A misaligned store is dropped.
  - No access: outputs idle.
- Byte enables:
  - b: 4'b0001<<addr[1:0].
  - h: 4'b0011<<addr[1:0].
  - w: 4'b1111.
  - Reads use the same be.
- Store data: bus_wdata = WriteDataM replicated (byte x4, half x2), so lanes line up with bus_be.
- BUSY:
  - bus_req=1 and StallM=1; the counter increments each cycle.
  - bus_ack=1: capture bus_rdata and go to DONE.
  - counter==TIMEOUT-1 without ack: capture 0, set the err flag, go to DONE. bus_req drops on that edge.
  - Request fields stay stable for the whole BUSY state.
- DONE:
  - bus_req=0, StallM=0, so the pipeline advances at the end of this cycle.
  - ReadDataM is formatted from the captured word and shifted by the registered addr[1:0] >>8 per byte offset. b/h sign-extend; bu/hu zero-extend; w passes through.
  - BusErrM=1 if the err flag is set.
  - Next edge: go to IDLE, clear counter and err flag. The new memory-stage instruction is evaluated in IDLE on the cycle after DONE.
- Latency: a load/store with ack in the first BUSY cycle stalls for 2 cycles (IDLE-detect, BUSY) and completes in DONE. Each extra wait cycle adds one stall cycle.
- ReadDataM is 0 in IDLE and BUSY, and for stores in DONE.
- Reset mid-access: immediate return to IDLE; bus_req drops asynchronously; a late bus_ack is ignored.
- bus_ack outside BUSY is ignored.

Test Plan:
- lw at 0x100, ack in 1st BUSY cycle, rdata 0xDEADBEEF -> bus_addr 0x100, be 1111, StallM high 2 cycles, ReadDataM=0xDEADBEEF in DONE.
- lb at 0x103, rdata 0x80FF_0000 -> be 1000, ReadDataM=0xFFFFFF80. The same access as lbu -> 0x00000080.
- sh at 0x202 with WriteDataM 0x1234ABCD -> bus_we=1, bus_addr 0x200, be 1100, bus_wdata 0xABCDABCD, ReadDataM=0.
- lw at 0x102 -> MisalignM pulse, bus_req never asserted, StallM=0, ReadDataM=0.
- lw, no ack, TIMEOUT=16 -> bus_req high 16 cycles, BusErrM pulse in DONE, ReadDataM=0, FSM back to IDLE.
- reset asserted on the 3rd BUSY cycle, ack 1 cycle after reset release -> bus_req=0 immediately, no DONE, ack ignored.
